// File: rtl/mole_position_gen.sv
// Whack-a-mole sequencer: LFSR-picked hole, timed show/gap phases,
// saturating hit and miss counters.
module mole_position_gen #(
  parameter logic [7:0] LFSR_SEED  = 8'hA5,
  parameter int unsigned SHOW_TICKS = 4,
  parameter int unsigned GAP_TICKS  = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       tick,
  input  logic       start,
  input  logic       stop,
  input  logic       hit_valid,
  input  logic [3:0] hit_pos,
  output logic [4:0] mole_position,
  output logic [7:0] score,
  output logic [7:0] miss_cnt,
  output logic       game_active
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    GAP  = 2'd1,
    SHOW = 2'd2
  } state_t;

  localparam logic [3:0] SHOW_N = 4'(SHOW_TICKS);
  localparam logic [3:0] GAP_N  = 4'(GAP_TICKS);
  localparam logic [4:0] NONE   = 5'd16;

  state_t     state, state_n;
  logic [7:0] lfsr, lfsr_n;
  logic [3:0] cnt, cnt_n;
  logic [3:0] last_pos, last_pos_n;
  logic [4:0] pos_n;
  logic [7:0] score_n, miss_n;
  logic       active_n;

  logic       fb;
  logic [3:0] cnt_inc;
  logic [3:0] cand;
  logic [3:0] pick;
  logic       hit;

  assign fb      = lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3];
  assign cnt_inc = cnt + 4'd1;
  assign cand    = lfsr[3:0];
  // bump by one so the same hole never shows twice in a row
  assign pick    = (cand == last_pos) ? cand + 4'd1 : cand;
  assign hit     = hit_valid && (hit_pos == mole_position[3:0]);

  always_comb begin
    state_n    = state;
    lfsr_n     = {lfsr[6:0], fb};
    cnt_n      = cnt;
    last_pos_n = last_pos;
    pos_n      = mole_position;
    score_n    = score;
    miss_n     = miss_cnt;
    if (stop) begin
      state_n = IDLE;
      pos_n   = NONE;
      cnt_n   = 4'd0;
    end else begin
      unique case (state)
        IDLE: begin
          pos_n = NONE;
          if (start) begin
            state_n = GAP;
            score_n = 8'd0;
            miss_n  = 8'd0;
            cnt_n   = 4'd0;
          end
        end
        GAP: begin
          pos_n = NONE;
          if (tick) begin
            cnt_n = cnt_inc;
            if (cnt_inc == GAP_N) begin
              pos_n      = {1'b0, pick};
              last_pos_n = pick;
              cnt_n      = 4'd0;
              state_n    = SHOW;
            end
          end
        end
        SHOW: begin
          if (hit) begin
            if (score != 8'hFF) score_n = score + 8'd1;
            pos_n   = NONE;
            cnt_n   = 4'd0;
            state_n = GAP;
          end else if (tick) begin
            cnt_n = cnt_inc;
            if (cnt_inc == SHOW_N) begin
              if (miss_cnt != 8'hFF) miss_n = miss_cnt + 8'd1;
              pos_n   = NONE;
              cnt_n   = 4'd0;
              state_n = GAP;
            end
          end
        end
        default: begin
          state_n = IDLE;
          pos_n   = NONE;
          cnt_n   = 4'd0;
        end
      endcase
    end
    active_n = (state_n != IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      lfsr          <= LFSR_SEED;
      cnt           <= 4'd0;
      last_pos      <= 4'd0;
      mole_position <= NONE;
      score         <= 8'd0;
      miss_cnt      <= 8'd0;
      game_active   <= 1'b0;
    end else begin
      state         <= state_n;
      lfsr          <= lfsr_n;
      cnt           <= cnt_n;
      last_pos      <= last_pos_n;
      mole_position <= pos_n;
      score         <= score_n;
      miss_cnt      <= miss_n;
      game_active   <= active_n;
    end
  end

endmodule
